// File: rtl/instr_encoder_loader_pkg.sv
// Shared encodings for the instruction encoder/loader: kind and ALU codes,
// ARM Op field values, FSM state encoding and the request payload struct.
package instr_enc_pkg;

  localparam int unsigned KIND_W  = 3;
  localparam int unsigned ALU_W   = 4;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned IMM12_W = 12;
  localparam int unsigned IMM24_W = 24;
  localparam int unsigned WORD_W  = 32;

  localparam logic [KIND_W-1:0] KIND_DP_REG = 3'd0;
  localparam logic [KIND_W-1:0] KIND_DP_IMM = 3'd1;
  localparam logic [KIND_W-1:0] KIND_LDR    = 3'd2;
  localparam logic [KIND_W-1:0] KIND_STR    = 3'd3;
  localparam logic [KIND_W-1:0] KIND_B      = 3'd4;
  localparam logic [KIND_W-1:0] KIND_HALT   = 3'd5;

  // Values match the core's Funct[4:1] decode
  localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_ADD = 4'b0100;
  localparam logic [ALU_W-1:0] ALU_CMP = 4'b1010;
  localparam logic [ALU_W-1:0] ALU_ORR = 4'b1100;
  localparam logic [ALU_W-1:0] ALU_LSR = 4'b1101;
  localparam logic [ALU_W-1:0] ALU_LSL = 4'b1110;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACCEPT  = 3'd1,
    ST_WRITE   = 3'd2,
    ST_VERIFY  = 3'd3,
    ST_COMPARE = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  typedef struct packed {
    logic [KIND_W-1:0]  kind;
    logic [ALU_W-1:0]   alu_op;
    logic               set_flags;
    logic [3:0]         cond;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   rn;
    logic [REG_W-1:0]   rm;
    logic [IMM12_W-1:0] imm12;
    logic [IMM24_W-1:0] imm24;
  } req_t;

  function automatic logic alu_legal(input logic [ALU_W-1:0] op);
    return (op == ALU_AND) || (op == ALU_SUB) || (op == ALU_ADD) ||
           (op == ALU_CMP) || (op == ALU_ORR) || (op == ALU_LSR) ||
           (op == ALU_LSL);
  endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Request handshake and instruction-memory write bus of the encoder/loader.
// Readback signals exist only when ENC_READBACK_EN is defined.
interface instr_encoder_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        kind;
  logic [3:0]        alu_op;
  logic              set_flags;
  logic [3:0]        cond;
  logic [3:0]        rd;
  logic [3:0]        rn;
  logic [3:0]        rm;
  logic [11:0]       imm12;
  logic [23:0]       imm24;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
`ifdef ENC_READBACK_EN
  logic              mem_re;
  logic [31:0]       mem_rdata;

  modport master (
    output req_valid, kind, alu_op, set_flags, cond, rd, rn, rm, imm12, imm24,
    output mem_rdata,
    input  req_ready, mem_we, mem_addr, mem_wdata, mem_re
  );
  modport slave (
    input  req_valid, kind, alu_op, set_flags, cond, rd, rn, rm, imm12, imm24,
    input  mem_rdata,
    output req_ready, mem_we, mem_addr, mem_wdata, mem_re
  );
`else
  modport master (
    output req_valid, kind, alu_op, set_flags, cond, rd, rn, rm, imm12, imm24,
    input  req_ready, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  req_valid, kind, alu_op, set_flags, cond, rd, rn, rm, imm12, imm24,
    output req_ready, mem_we, mem_addr, mem_wdata
  );
`endif
endinterface

// File: rtl/instr_encoder_loader_word_pack.sv
// Combinational fields-to-word packer for the ARM subset, with a legal flag.
// Also usable standalone as a golden encoder.
module instr_word_pack
  import instr_enc_pkg::*;
(
  input  req_t        req,
  output logic [31:0] word_c,
  output logic        legal_c
);

  logic        s_bit;
  logic        i_bit;
  logic [3:0]  rd_f;
  logic [11:0] src2;

  always_comb begin
    word_c  = '0;
    legal_c = 1'b0;
    s_bit   = req.set_flags;
    i_bit   = (req.kind == KIND_DP_IMM);
    rd_f    = req.rd;
    src2    = i_bit ? req.imm12 : {8'b0, req.rm};
    // CMP only writes flags: S is forced on and Rd is zeroed
    if (req.alu_op == ALU_CMP) begin
      s_bit = 1'b1;
      rd_f  = 4'd0;
    end
    case (req.kind)
      KIND_DP_REG, KIND_DP_IMM: begin
        legal_c = alu_legal(req.alu_op);
        word_c  = {req.cond, OP_DP, i_bit, req.alu_op, s_bit, req.rn, rd_f, src2};
      end
      KIND_LDR, KIND_STR: begin
        legal_c = 1'b1;
        word_c  = {req.cond, OP_MEM, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                   (req.kind == KIND_LDR), req.rn, req.rd, req.imm12};
      end
      KIND_B: begin
        legal_c = 1'b1;
        word_c  = {req.cond, OP_BR, 2'b10, req.imm24};
      end
      KIND_HALT: legal_c = 1'b1;
      default:   legal_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Sequential instruction encoder/program loader: accepts fields, writes packed
// words to consecutive memory addresses. ENC_READBACK_EN adds a write-verify pass.
module instr_encoder_loader
  import instr_enc_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned DEPTH     = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  instr_encoder_loader_if.slave        bus,
  output logic                         busy,
  output logic                         done,
  output logic                         err_illegal,
  output logic                         full,
`ifdef ENC_READBACK_EN
  output logic                         err_verify,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              done_q, done_d;
  logic              ill_q, ill_d;
  logic              full_q, full_d;
  logic              we_q, ready_q, busy_q;
  logic              legal_c;
  logic [31:0]       word_c;
  req_t              req;
`ifdef ENC_READBACK_EN
  logic              ver_q, ver_d;
  logic              re_q;
`endif

  assign req = '{kind: bus.kind, alu_op: bus.alu_op, set_flags: bus.set_flags,
                 cond: bus.cond, rd: bus.rd, rn: bus.rn, rm: bus.rm,
                 imm12: bus.imm12, imm24: bus.imm24};

  instr_word_pack u_pack (
    .req     (req),
    .word_c  (word_c),
    .legal_c (legal_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath next values
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    done_d  = done_q;
    ill_d   = ill_q;
    full_d  = full_q;
`ifdef ENC_READBACK_EN
    ver_d   = ver_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          count_d = '0;
          done_d  = 1'b0;
          ill_d   = 1'b0;
          full_d  = 1'b0;
          addr_d  = ADDR_W'(BASE_ADDR);
`ifdef ENC_READBACK_EN
          ver_d   = 1'b0;
`endif
          state_d = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        if (bus.req_valid) begin
          if (!legal_c) begin
            ill_d = 1'b1;
          end else if (bus.kind == KIND_HALT) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            wdata_d = word_c;
            state_d = ST_WRITE;
          end
        end
      end
`ifdef ENC_READBACK_EN
      ST_WRITE:  state_d = ST_VERIFY;
      ST_VERIFY: state_d = ST_COMPARE;
      ST_COMPARE: begin
        if (bus.mem_rdata != wdata_q) ver_d = 1'b1;
`else
      ST_WRITE: begin
`endif
        count_d = count_q + CNT_W'(1);
        addr_d  = addr_q + ADDR_W'(4);
        if (count_d == CNT_W'(DEPTH)) begin
          full_d  = 1'b1;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_ACCEPT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs decoded from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= ADDR_W'(BASE_ADDR);
      wdata_q <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
      full_q  <= 1'b0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef ENC_READBACK_EN
      ver_q   <= 1'b0;
      re_q    <= 1'b0;
`endif
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
      full_q  <= full_d;
      we_q    <= (state_d == ST_WRITE);
      ready_q <= (state_d == ST_ACCEPT);
      busy_q  <= (state_d != ST_IDLE) && (state_d != ST_DONE);
`ifdef ENC_READBACK_EN
      ver_q   <= ver_d;
      re_q    <= (state_d == ST_VERIFY);
`endif
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_illegal   = ill_q;
  assign full          = full_q;
  assign count         = count_q;
`ifdef ENC_READBACK_EN
  assign bus.mem_re    = re_q;
  assign err_verify    = ver_q;
`endif

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Sequential instruction encoder and program loader for the multi-cycle ARM core.
- Accepts decoded instruction fields over a valid/ready handshake.
- Packs them into 32-bit ARM-subset words: the exact bit layout that the core's control decoder consumes (Op, Funct, Rd).
- Writes the words to consecutive instruction-memory addresses.
- Used by benches and boot logic to load programs before the core is released from reset.

Parameters:
ADDR_W, 8, instruction-memory byte-address width
BASE_ADDR, 0, first byte address written after start
DEPTH, 64, maximum number of words per program

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a program load
req_valid  in  1  instruction fields valid
req_ready  out  1  encoder can accept fields
kind  in  3  0 DP_REG, 1 DP_IMM, 2 LDR, 3 STR, 4 B, 5 HALT, 6-7 illegal
alu_op  in  4  Funct[4:1] command: ADD 0100, SUB 0010, AND 0000, ORR 1100, LSR 1101, LSL 1110, CMP 1010
set_flags  in  1  S bit for DP kinds
cond  in  4  condition field [31:28]
rd, rn, rm  in  4 each  register fields
imm12  in  12  DP immediate (src2) or memory offset
imm24  in  24  branch word offset
mem_we  out  1  instruction-memory write strobe
mem_addr  out  ADDR_W  byte address
mem_wdata  out  32  encoded word
busy  out  1  load in progress
done  out  1  sticky: HALT accepted or DEPTH reached
err_illegal  out  1  sticky: illegal kind or alu_op seen
full  out  1  DEPTH words written
count  out  $clog2(DEPTH+1)  words written

Behaviour:
- Reset values: every output is 0; mem_addr = BASE_ADDR; FSM = IDLE.
- FSM states: IDLE, ACCEPT, WRITE, DONE.
  - IDLE: req_ready = 0. On start: clear count, done, err_illegal and full; set mem_addr = BASE_ADDR; go to ACCEPT.
  - ACCEPT: req_ready = 1; busy = 1. When req_valid is high:
    - Legal non-HALT request: register the word into mem_wdata; go to WRITE.
    - HALT: go to DONE; set done; nothing is written.
    - Illegal request: set err_illegal; stay in ACCEPT; no write; count unchanged.
  - WRITE: mem_we = 1 for exactly one cycle. Then count += 1 and mem_addr += 4.
    - If the new count equals DEPTH: set full and done; go to DONE.
    - Otherwise: go to ACCEPT.
  - DONE: req_ready = 0; busy = 0. On start: behave as IDLE on start.
- Latency and throughput: a handshake in cycle N produces mem_we in cycle N+1. Throughput is one word per 2 cycles.
- start outside IDLE or DONE is ignored.
- Encoding, DP kinds:
  - Word = {cond, 2'b00, I, alu_op, S, rn, rd, src2}.
  - I = 1 for DP_IMM; src2 = imm12.
  - I = 0 for DP_REG; src2 = {8'b0, rm}.
  - CMP forces S = 1 and rd = 0.
  - Any other alu_op not in the table is illegal.
- Encoding, LDR/STR: word = {cond, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, L, rn, rd, imm12}. L = 1 for LDR.
- Encoding, B: word = {cond, 2'b10, 2'b10, imm24}.
- rd = 15 is legal; the core's PC-write logic handles it.
- Address wrap: mem_addr arithmetic is modulo 2^ADDR_W. No error is raised on wrap.
- Reset asserted mid-operation: mem_we drops asynchronously and all state returns to reset values.

Optional Feature:
ENC_READBACK_EN
- When defined:
  - Adds input mem_rdata[31:0] and outputs mem_re and err_verify (sticky).
  - WRITE is followed by VERIFY. In VERIFY, mem_re = 1 at the same mem_addr. On the next cycle mem_rdata is compared with the registered word; a mismatch sets err_verify. count and mem_addr then advance.
  - Throughput becomes one word per 4 cycles.
  - err_verify resets to 0 and is cleared by start.
- When undefined: none of these ports exist, and timing is as above.

Decomposition:
- Package instr_enc_pkg holds:
  - kind codes and alu_op codes, matching the core's Funct[4:1] values;
  - Op field constants (00 DP, 01 MEM, 10 BR);
  - FSM state encoding.
- Sub-module instr_word_pack: purely combinational fields-to-word packer with a legal flag. It is reused by benches as a golden encoder.

Test Plan:
1. Reset, then start; send DP_IMM ADD (cond=E, rn=1, rd=2, imm12=0x005, S=0) -> mem_we one cycle later, mem_addr=0x00, mem_wdata=0xE2812005, count=1.
2. Send LDR rd=3, rn=0, imm12=0x010, then STR rd=3, rn=0, imm12=0x014 -> words 0xE5903010 at addr 0x00 and 0xE5803014 at addr 0x04; req_ready low on each WRITE cycle.
3. Send CMP DP_REG with rd=7, rn=1, rm=2, S=0 -> 0xE1510002 (S forced to 1, rd forced to 0).
4. Send kind=6, then alu_op=0111 -> err_illegal=1, no mem_we, count unchanged; a following legal request is still written.
5. DEPTH=4: send 5 B requests (imm24=0xFFFFFE) -> 4 writes of 0xEAFFFFFE, full=1 and done=1 after the 4th, fifth request never accepted; HALT mid-stream sets done with no write.
6. Assert reset during WRITE -> mem_we drops immediately, count=0 and mem_addr=BASE_ADDR; with ENC_READBACK_EN, a corrupted mem_rdata sets err_verify=1.
